// File: rtl/rc4_encrypt_fsm_if.sv
// Control and memory-port bundle for the RC4 encryption sequencer.
// The master modport is the engine side; slave is the environment holding the memories.
interface rc4_encrypt_fsm_if;
  logic        start;
  logic        stop;
  logic [23:0] secret_key;
  logic [7:0]  s_address;
  logic [7:0]  s_data;
  logic        s_wren;
  logic        s_rden;
  logic [7:0]  s_q;
  logic [4:0]  pt_address;
  logic        pt_rden;
  logic [7:0]  pt_q;
  logic [4:0]  ct_address;
  logic [7:0]  ct_data;
  logic        ct_wren;
  logic        busy;
  logic        done;

  modport master (
    input  start, stop, secret_key, s_q, pt_q,
    output s_address, s_data, s_wren, s_rden,
    output pt_address, pt_rden,
    output ct_address, ct_data, ct_wren,
    output busy, done
  );

  modport slave (
    output start, stop, secret_key, s_q, pt_q,
    input  s_address, s_data, s_wren, s_rden,
    input  pt_address, pt_rden,
    input  ct_address, ct_data, ct_wren,
    input  busy, done
  );
endinterface

// File: rtl/rc4_encrypt_fsm.sv
// RC4 encryption sequencer: fills and shuffles an external S memory, then writes
// plaintext XOR keystream into the ciphertext RAM, one byte per 11-cycle PRGA round.
module rc4_encrypt_fsm #(
  parameter int MSG_LEN = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  rc4_encrypt_fsm_if.master bus
);

  typedef enum logic [4:0] {
    IDLE, INIT,
    K_RDI, K_WTI, K_CALC, K_RDJ, K_WTJ, K_WRI, K_WRJ,
    P_INC, P_RDI, P_WTI, P_CALC, P_RDJ, P_WTJ, P_WRI, P_WRJ,
    P_RDF, P_WTF, P_WRC,
    DONE
  } state_t;

  localparam logic [4:0] LAST_K = 5'(MSG_LEN - 1);

  state_t      r_state, w_next;
  logic [7:0]  r_i, r_j, r_si, r_sj, r_f, r_p;
  logic [4:0]  r_k;
  logic [23:0] r_key;
  logic [1:0]  r_kidx;
  logic [7:0]  w_keybyte;
  logic        w_accept;

  assign w_accept = bus.start && !bus.stop && (r_state == IDLE || r_state == DONE);

  // r_kidx tracks i mod 3 so the key byte is a simple mux.
  always_comb begin
    case (r_kidx)
      2'd0:    w_keybyte = r_key[23:16];
      2'd1:    w_keybyte = r_key[15:8];
      default: w_keybyte = r_key[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    bus.s_address  = 8'd0;
    bus.s_data     = 8'd0;
    bus.s_wren     = 1'b0;
    bus.s_rden     = 1'b0;
    bus.pt_address = 5'd0;
    bus.pt_rden    = 1'b0;
    bus.ct_address = 5'd0;
    bus.ct_data    = 8'd0;
    bus.ct_wren    = 1'b0;
    bus.busy       = (r_state != IDLE) && (r_state != DONE);
    bus.done       = (r_state == DONE);
    case (r_state)
      IDLE, DONE: if (w_accept) w_next = INIT;
      INIT: begin
        bus.s_address = r_i;
        bus.s_data    = r_i;
        bus.s_wren    = 1'b1;
        if (r_i == 8'd255) w_next = K_RDI;
      end
      K_RDI:  begin bus.s_address = r_i; bus.s_rden = 1'b1; w_next = K_WTI; end
      K_WTI:  w_next = K_CALC;
      K_CALC: w_next = K_RDJ;
      K_RDJ:  begin bus.s_address = r_j; bus.s_rden = 1'b1; w_next = K_WTJ; end
      K_WTJ:  w_next = K_WRI;
      K_WRI:  begin bus.s_address = r_i; bus.s_data = r_sj; bus.s_wren = 1'b1; w_next = K_WRJ; end
      K_WRJ: begin
        bus.s_address = r_j;
        bus.s_data    = r_si;
        bus.s_wren    = 1'b1;
        w_next        = (r_i == 8'd255) ? P_INC : K_RDI;
      end
      P_INC:  w_next = P_RDI;
      P_RDI:  begin bus.s_address = r_i; bus.s_rden = 1'b1; w_next = P_WTI; end
      P_WTI:  w_next = P_CALC;
      P_CALC: w_next = P_RDJ;
      P_RDJ:  begin bus.s_address = r_j; bus.s_rden = 1'b1; w_next = P_WTJ; end
      P_WTJ:  w_next = P_WRI;
      P_WRI:  begin bus.s_address = r_i; bus.s_data = r_sj; bus.s_wren = 1'b1; w_next = P_WRJ; end
      // When i == j the second write (si) lands last, matching the software swap.
      P_WRJ:  begin bus.s_address = r_j; bus.s_data = r_si; bus.s_wren = 1'b1; w_next = P_RDF; end
      P_RDF: begin
        bus.s_address  = r_si + r_sj;
        bus.s_rden     = 1'b1;
        bus.pt_address = r_k;
        bus.pt_rden    = 1'b1;
        w_next         = P_WTF;
      end
      P_WTF:  w_next = P_WRC;
      P_WRC: begin
        bus.ct_address = r_k;
        bus.ct_data    = r_f ^ r_p;
        bus.ct_wren    = 1'b1;
        w_next         = (r_k == LAST_K) ? DONE : P_INC;
      end
      default: w_next = IDLE;
    endcase
    if (bus.stop) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_i    <= 8'd0;
      r_j    <= 8'd0;
      r_k    <= 5'd0;
      r_si   <= 8'd0;
      r_sj   <= 8'd0;
      r_f    <= 8'd0;
      r_p    <= 8'd0;
      r_key  <= 24'd0;
      r_kidx <= 2'd0;
    end else if (!bus.stop) begin
      case (r_state)
        IDLE, DONE: if (w_accept) begin
          r_key  <= bus.secret_key;
          r_i    <= 8'd0;
          r_j    <= 8'd0;
          r_k    <= 5'd0;
          r_kidx <= 2'd0;
        end
        INIT:   r_i <= r_i + 8'd1;
        K_WTI:  r_si <= bus.s_q;
        K_CALC: r_j <= r_j + r_si + w_keybyte;
        K_WTJ:  r_sj <= bus.s_q;
        K_WRJ: begin
          if (r_i == 8'd255) begin
            r_i <= 8'd0;
            r_j <= 8'd0;
            r_k <= 5'd0;
          end else begin
            r_i    <= r_i + 8'd1;
            r_kidx <= (r_kidx == 2'd2) ? 2'd0 : r_kidx + 2'd1;
          end
        end
        P_INC:  r_i <= r_i + 8'd1;
        P_WTI:  r_si <= bus.s_q;
        P_CALC: r_j <= r_j + r_si;
        P_WTJ:  r_sj <= bus.s_q;
        P_WTF: begin
          r_f <= bus.s_q;
          r_p <= bus.pt_q;
        end
        P_WRC:  if (r_k != LAST_K) r_k <= r_k + 5'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_encrypt_fsm.sv
// Bench for rc4_encrypt_fsm: memory models, a ciphertext scoreboard fed from a
// software RC4 reference, and directed control-corner scenarios.
module tb_rc4_encrypt_fsm;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  rc4_encrypt_fsm_if bus ();
  rc4_encrypt_fsm_if b2 ();

  rc4_encrypt_fsm #(.MSG_LEN(32)) dut  (.clk(clk), .reset_n(reset_n), .bus(bus));
  rc4_encrypt_fsm #(.MSG_LEN(1))  dut2 (.clk(clk), .reset_n(reset_n), .bus(b2));

  logic [7:0] smem [256];
  logic [7:0] pmem [32];
  logic [7:0] cmem [32];
  logic [7:0] smem2 [256];
  logic [7:0] ks [32];

  always @(posedge clk) begin
    if (bus.s_wren)  smem[bus.s_address] <= bus.s_data;
    if (bus.s_rden)  bus.s_q <= smem[bus.s_address];
    if (bus.pt_rden) bus.pt_q <= pmem[bus.pt_address];
    if (bus.ct_wren) cmem[bus.ct_address] <= bus.ct_data;
    if (b2.s_wren)   smem2[b2.s_address] <= b2.s_data;
    if (b2.s_rden)   b2.s_q <= smem2[b2.s_address];
    if (b2.pt_rden)  b2.pt_q <= 8'h00;
  end

  int cyc = 0;
  int e0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct { logic [4:0] a; logic [7:0] d; int e; } exp_t;
  exp_t q [$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Scoreboard monitor: every ciphertext write is matched against the queue head.
  always @(negedge clk) begin : mon
    exp_t x;
    if (reset_n && bus.ct_wren) begin
      if (q.size() == 0) begin
        check("ct_unexpected_write", {59'd0, bus.ct_address}, 64'hFFFF);
      end else begin
        x = q.pop_front();
        check("ct_addr", {59'd0, bus.ct_address}, {59'd0, x.a});
        check("ct_data", {56'd0, bus.ct_data}, {56'd0, x.d});
        check("ct_edge", 64'(cyc - e0 + 1), 64'(x.e));
      end
    end
  end

  int n2 = 0, e2 = 0;
  logic [7:0] d2;
  always @(negedge clk) if (reset_n && b2.ct_wren) begin
    n2 <= n2 + 1;
    e2 <= cyc - e0 + 1;
    d2 <= b2.ct_data;
  end

  function automatic logic [7:0] asc(input int k);
    return 8'(8'h61 + k % 26);
  endfunction

  function automatic logic [63:0] outs();
    return {24'd0, bus.s_address, bus.s_data, bus.s_wren, bus.s_rden, bus.pt_address,
            bus.pt_rden, bus.ct_address, bus.ct_data, bus.ct_wren, bus.busy, bus.done};
  endfunction

  task automatic rc4_ref(input logic [23:0] key);
    logic [7:0] S [256];
    logic [7:0] t;
    int j, ii;
    for (int n = 0; n < 256; n++) S[n] = 8'(n);
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + int'(S[n]) + int'(key[23 - 8 * (n % 3) -: 8])) % 256;
      t = S[n]; S[n] = S[j]; S[j] = t;
    end
    ii = 0; j = 0;
    for (int k = 0; k < 32; k++) begin
      ii = (ii + 1) % 256;
      j = (j + int'(S[ii])) % 256;
      t = S[ii]; S[ii] = S[j]; S[j] = t;
      ks[k] = S[(int'(S[ii]) + int'(S[j])) % 256];
    end
  endtask

  task automatic push_ks();
    for (int k = 0; k < 32; k++) q.push_back('{5'(k), ks[k] ^ pmem[k], 2048 + 11 * k + 11});
  endtask

  task automatic start_run(input logic [23:0] key, input bit both);
    bus.secret_key = key;
    bus.start = 1'b1;
    b2.start = both;
    @(negedge clk);
    e0 = cyc;
    bus.start = 1'b0;
    b2.start = 1'b0;
  endtask

  task automatic wait_edge(input int n);
    int t;
    t = 0;
    while (cyc - e0 < n && t < 5000) begin @(negedge clk); t++; end
  endtask

  task automatic wait_done(input string nm, input int expe);
    int t;
    t = 0;
    while (!bus.done && t < 4000) begin @(negedge clk); t++; end
    check(nm, 64'(cyc - e0), 64'(expe));
  endtask

  initial begin
    int wr, rd, bad;
    bus.start = 0; bus.stop = 0; bus.secret_key = 0;
    b2.start = 0; b2.stop = 0; b2.secret_key = 24'h000001;
    reset_n = 1'b0;
    for (int k = 0; k < 32; k++) pmem[k] = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 64'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_reset", {62'd0, bus.busy, bus.done}, 64'd0);

    // INIT pass with key 0, then full run
    rc4_ref(24'h000000); push_ks();
    start_run(24'h000000, 1'b0);
    wr = 0; rd = 0; bad = 0;
    for (int n = 0; n < 256; n++) begin
      if (bus.s_wren) wr++;
      if (bus.s_rden) rd++;
      if (bus.s_address !== 8'(n) || bus.s_data !== 8'(n)) bad++;
      @(negedge clk);
    end
    check("init_write_count", 64'(wr), 64'd256);
    check("init_rden_count", 64'(rd), 64'd0);
    check("init_addr_data", 64'(bad), 64'd0);
    bad = 0;
    for (int n = 0; n < 256; n++) if (smem[n] !== 8'(n)) bad++;
    check("init_contents", 64'(bad), 64'd0);
    wait_done("done_edge_key0", 2400);
    repeat (3) @(negedge clk);
    check("done_holds", {62'd0, bus.busy, bus.done}, 64'd1);

    // Known answer key 000001, plus MSG_LEN=1 instance alongside
    rc4_ref(24'h000001); push_ks();
    start_run(24'h000001, 1'b1);
    check("done_drops_on_start", {62'd0, bus.busy, bus.done}, 64'd2);
    wait_done("done_edge_key1", 2400);
    check("len1_pulses", 64'(n2), 64'd1);
    check("len1_edge", 64'(e2), 64'd2059);
    check("len1_data", {56'd0, d2}, {56'd0, ks[0]});
    check("len1_done", {63'd0, b2.done}, 64'd1);

    rc4_ref(24'h3FFFFF); push_ks();
    start_run(24'h3FFFFF, 1'b0);
    wait_done("done_edge_key3f", 2400);

    // Round trip with start pulse and key change mid-run, then zero-idle restart
    for (int k = 0; k < 32; k++) pmem[k] = asc(k);
    rc4_ref(24'h0ABCDE); push_ks();
    start_run(24'h0ABCDE, 1'b0);
    wait_edge(500);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_ignored_busy", {62'd0, bus.busy, bus.done}, 64'd2);
    wait_edge(700);
    bus.secret_key = 24'h123456;
    wait_done("done_edge_rt1", 2400);
    bus.secret_key = 24'h0ABCDE;
    bus.start = 1'b1;
    @(negedge clk);
    e0 = cyc;
    bus.start = 1'b0;
    check("restart_zero_idle", {62'd0, bus.busy, bus.done}, 64'd2);
    for (int k = 0; k < 32; k++) pmem[k] = cmem[k];
    for (int k = 0; k < 32; k++) q.push_back('{5'(k), asc(k), 2048 + 11 * k + 11});
    wait_done("done_edge_rt2", 2400);

    // Abort during KSA, then clean restart
    for (int k = 0; k < 32; k++) pmem[k] = asc(k);
    start_run(24'h0ABCDE, 1'b0);
    wait_edge(999);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check("abort_idle", {62'd0, bus.busy, bus.done}, 64'd0);
    bad = 0;
    for (int n = 0; n < 30; n++) begin
      if (bus.s_wren || bus.s_rden || bus.pt_rden || bus.ct_wren) bad++;
      @(negedge clk);
    end
    check("abort_quiet", 64'(bad), 64'd0);
    rc4_ref(24'h0ABCDE); push_ks();
    start_run(24'h0ABCDE, 1'b0);
    wait_done("done_edge_after_abort", 2400);

    // Asynchronous reset mid-KSA
    start_run(24'h000001, 1'b0);
    wait_edge(500);
    #1 reset_n = 1'b0;
    #1 check("reset_mid_outputs", outs(), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_after_mid_reset", {62'd0, bus.busy, bus.done}, 64'd0);

    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rc4_encrypt_fsm.md
# rc4_encrypt_fsm

RC4 encryption engine that writes the ciphertext the key-search cores later consume. Given a 24-bit secret key and a plaintext message, it initializes and shuffles an external 256x8 S memory, runs the RC4 keystream generator, and writes ciphertext = plaintext XOR keystream into an external ciphertext RAM. It supplies known-key ciphertext images for the `Encode_ROM` / decrypt path and round-trip benches. It is a single-master sequencer: it owns its S memory, plaintext RAM and ciphertext RAM ports exclusively, with no mux.

## Interface
- `MSG_LEN`, default 32: message length in bytes, range 1..32; the address ports are 5 bits.
- `clk` in 1: the single clock, rising-edge.
- `reset_n` in 1: asynchronous active-low reset.
- `start` in 1: begin encryption; sampled only in IDLE or DONE.
- `stop` in 1: synchronous abort to IDLE; takes priority over every other input except reset.
- `secret_key` in 24: key, sampled into a register on start acceptance. Key byte 0 = [23:16], byte 1 = [15:8], byte 2 = [7:0].
- `s_address` out 8, `s_data` out 8, `s_wren` out 1, `s_rden` out 1: S memory port.
- `s_q` in 8: S memory read data.
- `pt_address` out 5, `pt_rden` out 1: plaintext RAM read port.
- `pt_q` in 8: plaintext RAM read data.
- `ct_address` out 5, `ct_data` out 8, `ct_wren` out 1: ciphertext RAM write port.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: high in DONE; stays high until the next start is accepted, or until stop or reset.

## Operation
- **Reset:** all outputs 0. State = IDLE. Registers i, j, k, si, sj, f, key = 0.
- **Memory read model:** an address driven in cycle N returns `s_q` or `pt_q` valid in cycle N+1. The block registers the data at the end of cycle N+1 (the WT state).
- **IDLE / DONE:**
  - start=1 → latch key, clear i, j and k, go to INIT.
  - In DONE, `done` drops on that same edge.
- **INIT:** 256 cycles. Cycle n drives `s_address`=n, `s_data`=n, `s_wren`=1. After n=255, go to K_RDI with i=0 and j=0.
- **KSA:** 7 states per i; i runs 0..255.
  - K_RDI: `s_address`=i, `s_rden`=1.
  - K_WTI: si <= `s_q`.
  - K_CALC: j <= j + si + key[i mod 3], 8-bit wrap.
  - K_RDJ: `s_address`=j, `s_rden`=1.
  - K_WTJ: sj <= `s_q`.
  - K_WRI: write S[i]=sj.
  - K_WRJ: write S[j]=si. If i=255: go to P_INC with i=0, j=0, k=0. Otherwise i++ and go to K_RDI.
  - i mod 3 is kept as a 2-bit counter cycling 0,1,2. No divider.
- **PRGA:** 11 states per k; k runs 0..MSG_LEN-1.
  - P_INC: i <= i+1.
  - P_RDI: read S[i].
  - P_WTI: latch si.
  - P_CALC: j <= j+si.
  - P_RDJ: read S[j].
  - P_WTJ: latch sj.
  - P_WRI: write S[i]=sj.
  - P_WRJ: write S[j]=si.
  - P_RDF: `s_address`=si+sj (8-bit wrap), `s_rden`=1. In the same cycle `pt_address`=k, `pt_rden`=1.
  - P_WTF: f <= `s_q`, p <= `pt_q`.
  - P_WRC: `ct_address`=k, `ct_data`=f^p, `ct_wren`=1. If k=MSG_LEN-1, go to DONE. Otherwise k++ and go to P_INC.
- **Simultaneous write hazard:** when i=j, P_WRI and P_WRJ write the same location. The later write (si) wins, which is the correct RC4 result.
- **Quiet strobes:** write/read strobes are high only in the states listed above and are 0 in all other states. Address and data outputs are don't-care when their strobe is low.
- **stop:**
  - In any state, the next state is IDLE and busy=0.
  - Memory contents are left partial; no cleanup writes.
  - stop and start high together in IDLE → stays IDLE.
- **Start while busy:** ignored. `secret_key` changes while busy have no effect.
- **Reset mid-operation:** all outputs go to 0 immediately (asynchronous). Next state is IDLE.

## Timing
- Start accepted at edge E0.
- INIT occupies E1..E256. KSA takes 1792 cycles. PRGA takes 11·MSG_LEN cycles.
- DONE is entered at edge E0 + 2048 + 11·MSG_LEN. For MSG_LEN=32 that is E2400.
- `done` is registered and rises on that edge; `busy` falls on the same edge.
- Each ciphertext byte k is written at edge E0 + 2048 + 11k + 11.
- Restart from DONE has zero idle cycles: start held high across DONE re-enters INIT on the next edge.

## Test plan
- Reset values: assert reset_n=0 mid-KSA → all outputs 0 asynchronously. Release, hold start=0 → stays IDLE with busy=0, done=0.
- INIT check: start with key 24'h000000, pause at E256 → S[n]=n for all n, exactly 256 writes, `s_rden`=0 throughout INIT.
- Known-answer test: key 24'h000001 (and 24'h3FFFFF) with plaintext all 8'h00 → ciphertext equals the software RC4 keystream byte-for-byte. `done` rises at exactly E2400 and holds until the next start.
- Round trip: encrypt an ASCII plaintext "abcdefghijklmnopqrstuvwxyzabcdef" with key 24'h0ABCDE. Re-run with the ciphertext as plaintext → output equals the original 32 bytes.
- Abort and restart: assert stop at E1000 (KSA) → next edge IDLE, busy=0, done=0, no further memory strobes. A following start with the same key yields the same ciphertext as an uninterrupted run.
- Control corners:
  - start pulsed while busy → ignored, completion time unchanged.
  - `secret_key` toggled mid-run → output unchanged.
  - MSG_LEN=1 → a single `ct_wren` pulse at E2059.
